// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: turns the divided board clock and the run/step buttons into a
// single-cycle clock enable for the core. It supports free-run, pause and
// single-step modes, and counts every enable pulse it issues.
module cpu_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned STEP_CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  div_clk,
  input  logic                  btnU,
  input  logic                  btnC,
  output logic                  cpu_en,
  output logic                  running,
  output logic [STEP_CNT_W-1:0] step_count,
  output logic                  btnU_db,
  output logic                  btnC_db
);

  localparam int unsigned NB    = 2;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_STEP  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  logic [NB-1:0] raw;
  logic [NB-1:0] btn_db;
  logic [NB-1:0] press;
  logic          press_u;
  logic          press_c;

  logic          div_prev;
  logic          div_rise;

  state_t        state;
  state_t        state_next;
  logic          cpu_en_d;
  logic          running_d;

  // Bit 0 is the step button, bit 1 the run/pause button.
  assign raw = {btnC, btnU};

  // Per-button synchroniser, debouncer and press-edge detector.
  for (genvar g = 0; g < NB; g++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   db_q;
    logic                   db_prev_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Shift the raw button into the synchroniser chain.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[g]};
      end
    end

    // Accept a new level only after it has held for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
        db_q  <= 1'b0;
      end else if (s == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        db_q  <= s;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    // Delayed copy of the debounced level for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        db_prev_q <= 1'b0;
      end else begin
        db_prev_q <= db_q;
      end
    end

    assign btn_db[g] = db_q;
    assign press[g]  = db_q & ~db_prev_q;
  end

  assign press_u = press[0];
  assign press_c = press[1];
  assign btnU_db = btn_db[0];
  assign btnC_db = btn_db[1];

  // Remember the previous div_clk level; it is already in the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_prev <= 1'b0;
    end else begin
      div_prev <= div_clk;
    end
  end

  assign div_rise = div_clk & ~div_prev;

  // Mode state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_PAUSE;
    end else begin
      state <= state_next;
    end
  end

  // Mode transitions; run/pause wins over step, and STEP lasts one cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_PAUSE: begin
        if (press_c) begin
          state_next = ST_RUN;
        end else if (press_u) begin
          state_next = ST_STEP;
        end
      end
      ST_STEP: begin
        state_next = ST_PAUSE;
      end
      ST_RUN: begin
        if (press_c) begin
          state_next = ST_PAUSE;
        end
      end
      default: begin
        state_next = ST_PAUSE;
      end
    endcase
  end

  // Enable request: entering STEP, or a div_clk rise in RUN that is not being paused.
  always_comb begin
    cpu_en_d  = 1'b0;
    running_d = 1'b0;
    if (state_next == ST_STEP) begin
      cpu_en_d = 1'b1;
    end
    if ((state == ST_RUN) && div_rise && !press_c) begin
      cpu_en_d = 1'b1;
    end
    if (state_next == ST_RUN) begin
      running_d = 1'b1;
    end
  end

  // Registered enable and run indicator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_en  <= 1'b0;
      running <= 1'b0;
    end else begin
      cpu_en  <= cpu_en_d;
      running <= running_d;
    end
  end

  // Count issued enable pulses; wraps naturally at full width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_count <= '0;
    end else if (cpu_en) begin
      step_count <= step_count + STEP_CNT_W'(1);
    end
  end

  // One event never yields an enable on two consecutive cycles.
  a_en_single: assert property (@(posedge clk) disable iff (!reset) cpu_en |=> !cpu_en);

  // The run indicator always mirrors the mode register.
  a_running_state: assert property (@(posedge clk) disable iff (!reset) running == (state == ST_RUN));

  // STEP always falls back to PAUSE after one cycle.
  a_step_once: assert property (@(posedge clk) disable iff (!reset) (state == ST_STEP) |=> (state == ST_PAUSE));

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: scenario tasks plus randomised button traffic, all
// compared cycle by cycle against a behavioural model of the mode rules.
module tb_cpu_step_ctrl;

  localparam int unsigned DEB      = 4;
  localparam int unsigned SYNC     = 2;
  localparam int unsigned CW       = 4;
  localparam int          DIV_HALF = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          div_clk = 1'b0;
  logic          btnU = 1'b0;
  logic          btnC = 1'b0;
  logic          cpu_en;
  logic          running;
  logic [CW-1:0] step_count;
  logic          btnU_db;
  logic          btnC_db;

  int    n_checks = 0;
  int    n_fail = 0;
  int    mm_count = 0;
  string mm_msg = "";
  int    pulses = 0;
  int    db_u_seen = 0;
  int    phase = 0;
  bit    div_static = 1'b0;

  // Behavioural model state. Mode: 0 paused, 1 single step, 2 running.
  int m_pipe[2][SYNC];
  int m_db[2];
  int m_dbq[2];
  int m_hold[2];
  int m_mode;
  int m_div_prev;
  int m_en;
  int m_running;
  int m_count;
  int m_coinc;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYNC),
    .STEP_CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .div_clk   (div_clk),
    .btnU      (btnU),
    .btnC      (btnC),
    .cpu_en    (cpu_en),
    .running   (running),
    .step_count(step_count),
    .btnU_db   (btnU_db),
    .btnC_db   (btnC_db)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < int'(SYNC); k++) m_pipe[b][k] = 0;
      m_db[b] = 0;
      m_dbq[b] = 0;
      m_hold[b] = 0;
    end
    m_mode = 0;
    m_div_prev = 0;
    m_en = 0;
    m_running = 0;
    m_count = 0;
    m_coinc = 0;
  endfunction

  // One clock edge of the model, given the inputs present before the edge.
  function automatic void model_edge(input int u, input int c, input int d);
    int s[2];
    int pr[2];
    int rawv[2];
    int rise;
    int nm;
    rawv[0] = u;
    rawv[1] = c;
    for (int b = 0; b < 2; b++) begin
      s[b]  = m_pipe[b][SYNC-1];
      pr[b] = (m_db[b] == 1 && m_dbq[b] == 0) ? 1 : 0;
    end
    rise = (d == 1 && m_div_prev == 0) ? 1 : 0;
    nm = m_mode;
    if (m_mode == 0) begin
      if (pr[1] == 1) nm = 2;
      else if (pr[0] == 1) nm = 1;
    end else if (m_mode == 1) begin
      nm = 0;
    end else if (pr[1] == 1) begin
      nm = 0;
    end
    if (m_mode == 2 && pr[1] == 1 && rise == 1) m_coinc = 1;
    m_count   = (m_count + m_en) % (1 << CW);
    m_en      = (nm == 1 || (m_mode == 2 && rise == 1 && pr[1] == 0)) ? 1 : 0;
    m_running = (nm == 2) ? 1 : 0;
    m_mode    = nm;
    for (int b = 0; b < 2; b++) begin
      m_dbq[b] = m_db[b];
      if (s[b] != m_db[b]) begin
        m_hold[b]++;
        if (m_hold[b] == int'(DEB)) begin
          m_db[b] = s[b];
          m_hold[b] = 0;
        end
      end else begin
        m_hold[b] = 0;
      end
      for (int k = int'(SYNC) - 1; k > 0; k--) m_pipe[b][k] = m_pipe[b][k-1];
      m_pipe[b][0] = rawv[b];
    end
    m_div_prev = d;
  endfunction

  task automatic start_seg();
    mm_count = 0;
    mm_msg = "";
    pulses = 0;
    db_u_seen = 0;
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, and
  // record any disagreement with the model at the next falling edge.
  task automatic cycle(input int u, input int c);
    int d;
    if (div_static) d = int'(div_clk);
    else d = ((phase % 16) >= DIV_HALF) ? 1 : 0;
    phase++;
    btnU = 1'(u);
    btnC = 1'(c);
    div_clk = 1'(d);
    @(posedge clk);
    model_edge(u, c, d);
    @(negedge clk);
    if (cpu_en !== 1'(m_en) || running !== 1'(m_running) || step_count !== CW'(m_count) ||
        btnU_db !== 1'(m_db[0]) || btnC_db !== 1'(m_db[1])) begin
      mm_count++;
      if (mm_count == 1)
        mm_msg = $sformatf("t=%0t en=%b/%0d run=%b/%0d cnt=%0d/%0d dbU=%b/%0d dbC=%b/%0d",
                           $time, cpu_en, m_en, running, m_running, step_count, m_count,
                           btnU_db, m_db[0], btnC_db, m_db[1]);
    end
    if (cpu_en === 1'b1) pulses++;
    if (btnU_db === 1'b1) db_u_seen = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({cpu_en, running, step_count, btnU_db, btnC_db} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: outputs %b, required all zero",
               {cpu_en, running, step_count, btnU_db, btnC_db});
    end
    reset = 1'b1;
    model_reset();
    start_seg();
    repeat (100) cycle(0, 0);
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL reset_idle_pulses: got %0d, required 0", pulses); end
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL reset_idle_running: got %b, required 0", running); end
    n_checks++;
    if (step_count !== CW'(0)) begin n_fail++; $display("FAIL reset_idle_count: got %0d, required 0", step_count); end
    n_checks++;
    if (mm_count != 0) begin n_fail++; $display("FAIL reset_idle_model: %0d bad cycles, first %s, required 0", mm_count, mm_msg); end
  endtask

  task automatic test_step();
    int run_seen = 0;
    start_seg();
    for (int i = 0; i < 50; i++) begin
      cycle((i < 20) ? 1 : 0, 0);
      if (running === 1'b1) run_seen = 1;
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL step_pulses: got %0d, required 1", pulses); end
    n_checks++;
    if (step_count !== CW'(1)) begin n_fail++; $display("FAIL step_count: got %0d, required 1", step_count); end
    n_checks++;
    if (run_seen != 0) begin n_fail++; $display("FAIL step_running: running went high, required 0"); end
    n_checks++;
    if (mm_count != 0) begin n_fail++; $display("FAIL step_model: %0d bad cycles, first %s, required 0", mm_count, mm_msg); end
  endtask

  task automatic test_bounce();
    start_seg();
    for (int i = 0; i < 40; i++) cycle(((i / 2) % 2 == 0) ? 1 : 0, 0);
    repeat (20) cycle(0, 0);
    n_checks++;
    if (db_u_seen != 0) begin n_fail++; $display("FAIL bounce_db: btnU_db went high, required 0"); end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL bounce_pulses: got %0d, required 0", pulses); end
    n_checks++;
    if (step_count !== CW'(1)) begin n_fail++; $display("FAIL bounce_count: got %0d, required 1", step_count); end
    n_checks++;
    if (mm_count != 0) begin n_fail++; $display("FAIL bounce_model: %0d bad cycles, first %s, required 0", mm_count, mm_msg); end
  endtask

  task automatic test_run();
    int budget = 0;
    start_seg();
    repeat (10) cycle(0, 1);
    while (pulses < 5 && budget < 200) begin
      cycle(0, 0);
      budget++;
    end
    n_checks++;
    if (pulses != 5) begin n_fail++; $display("FAIL run_pulses: got %0d within budget, required 5", pulses); end
    cycle(0, 0);
    n_checks++;
    if (running !== 1'b1) begin n_fail++; $display("FAIL run_running: got %b, required 1", running); end
    n_checks++;
    if (step_count !== CW'(6)) begin n_fail++; $display("FAIL run_count: got %0d, required 6", step_count); end
    // Step button in RUN with div_clk frozen: nothing may fire.
    div_static = 1'b1;
    pulses = 0;
    repeat (20) cycle(1, 0);
    repeat (10) cycle(0, 0);
    while ((phase % 16) != 2) cycle(0, 0);
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL run_btnU_pulses: got %0d, required 0", pulses); end
    n_checks++;
    if (running !== 1'b1) begin n_fail++; $display("FAIL run_static_running: got %b, required 1", running); end
    n_checks++;
    if (step_count !== CW'(6)) begin n_fail++; $display("FAIL run_btnU_count: got %0d, required 6", step_count); end
    n_checks++;
    if (mm_count != 0) begin n_fail++; $display("FAIL run_model: %0d bad cycles, first %s, required 0", mm_count, mm_msg); end
  endtask

  // The press is timed so press_C lands on the same edge as a div_clk rise.
  task automatic test_pause_coincident();
    div_static = 1'b0;
    start_seg();
    repeat (10) cycle(0, 1);
    repeat (52) cycle(0, 0);
    n_checks++;
    if (m_coinc != 1) begin n_fail++; $display("FAIL pause_coinc_hit: coincidence flag %0d, required 1", m_coinc); end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL pause_pulses: got %0d, required 0", pulses); end
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL pause_running: got %b, required 0", running); end
    n_checks++;
    if (step_count !== CW'(6)) begin n_fail++; $display("FAIL pause_count: got %0d, required 6", step_count); end
    n_checks++;
    if (mm_count != 0) begin n_fail++; $display("FAIL pause_model: %0d bad cycles, first %s, required 0", mm_count, mm_msg); end
  endtask

  task automatic test_both_then_reset();
    div_static = 1'b1;
    start_seg();
    repeat (10) cycle(1, 1);
    repeat (10) cycle(0, 0);
    n_checks++;
    if (running !== 1'b1) begin n_fail++; $display("FAIL both_running: got %b, required 1", running); end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL both_no_step: got %0d pulses, required 0", pulses); end
    div_static = 1'b0;
    repeat (40) cycle(0, 0);
    n_checks++;
    if (mm_count != 0) begin n_fail++; $display("FAIL both_model: %0d bad cycles, first %s, required 0", mm_count, mm_msg); end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({cpu_en, running, step_count, btnU_db, btnC_db} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: outputs %b, required all zero",
               {cpu_en, running, step_count, btnU_db, btnC_db});
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_random();
    int u = 0;
    int c = 0;
    int lu = 0;
    int lc = 0;
    start_seg();
    for (int i = 0; i < 1500; i++) begin
      if (lu == 0) begin u = int'($urandom_range(0, 1)); lu = int'($urandom_range(1, 12)); end
      if (lc == 0) begin c = int'($urandom_range(0, 1)); lc = int'($urandom_range(1, 12)); end
      lu--;
      lc--;
      if (i % 200 == 0) div_static = ($urandom_range(0, 3) == 0);
      cycle(u, c);
    end
    div_static = 1'b0;
    n_checks++;
    if (mm_count != 0) begin n_fail++; $display("FAIL random_model: %0d bad cycles, first %s, required 0", mm_count, mm_msg); end
    n_checks++;
    if (pulses == 0) begin n_fail++; $display("FAIL random_activity: got 0 pulses, required at least 1"); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_step();
    test_bounce();
    test_run();
    test_pause_coincident();
    test_both_then_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
